host_bus_sync_if: RTL and testbench
===================================

# host_bus_sync_if

Parametrised, clocked host-bus interface between the asynchronous debugger bus and a system clock domain. The debugger bus is chip-select, write-enable and read-enable, all active low, plus address and bidirectional data. The block synchronises the host strobes and detects complete accesses with a small state machine. It turns each access into a single-cycle system write or read strobe and holds read data stable for the host until the strobe is released. It sits between the FPGA pad buffers and the system, replacing the direct unsynchronised pad-to-system connection.

## Interface
Parameters:
- DATA_W, 16, host/system data width
- ADDR_W, 6, host/system address width (word address)
- SYNC_STAGES, 2, synchroniser depth for ncs/nwe/nre (legal ≥2)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- host_ncs  in  1  chip select, active low, asynchronous to clk
- host_nwe  in  1  write enable, active low, asynchronous
- host_nre  in  1  read enable, active low, asynchronous
- host_addr  in  ADDR_W  host address, stable while strobes asserted
- host_data_in  in  DATA_W  data from pad input buffers
- host_data_out  out  DATA_W  registered read data to pad output buffers
- host_oe  out  1  pad drive enable, = ~(host_ncs | host_nre), combinational from raw pins
- sys_addr  out  ADDR_W  registered access address
- sys_wdata  out  DATA_W  registered write data
- sys_wr_en  out  1  one-cycle write strobe
- sys_rd_en  out  1  one-cycle read strobe
- sys_rdata  in  DATA_W  system read data, valid the cycle after sys_rd_en
- err_clr  in  1  clears err
- err  out  1  sticky protocol-error flag

## Operation
- Synchronisers: each of ncs/nwe/nre passes through SYNC_STAGES flops. Reset value 1 (inactive). The FSM sees only synchronised values: s_ncs, s_nwe, s_nre.
- FSM states: IDLE, RD_WAIT, RD_CAPT, HOLD.
- IDLE:
  - s_ncs=0, s_nwe=0, s_nre=1: register sys_addr←host_addr and sys_wdata←host_data_in; assert sys_wr_en next cycle; go to HOLD.
  - s_ncs=0, s_nre=0, s_nwe=1: register sys_addr; assert sys_rd_en next cycle; go to RD_WAIT.
  - s_ncs=0, s_nwe=0, s_nre=0: set err; no system access; go to HOLD.
  - Otherwise stay in IDLE.
- RD_WAIT: go to RD_CAPT after one cycle. sys_rd_en is high during this cycle.
- RD_CAPT: host_data_out←sys_rdata at the edge ending this cycle; go to HOLD.
- HOLD: stay until s_ncs=1, or both s_nwe=1 and s_nre=1; then go to IDLE. Exactly one system access is made per host strobe assertion.
- host_data_out changes only in RD_CAPT and otherwise holds its last value.
- sys_addr and sys_wdata hold their last value between accesses.
- err: set on the simultaneous-strobe condition. Cleared by err_clr when no set occurs in the same cycle; set wins over clear.
- Reset, at any time including mid-access: FSM→IDLE; sync flops→1; host_data_out, sys_addr, sys_wdata→0; sys_wr_en, sys_rd_en, err→0. A host access in progress at reset release is not serviced until it is released and reasserted. HOLD is not entered from reset.

## Timing
- Edge E0 is the first clk edge that samples the pin strobes asserted. Synchronised strobes become visible after edge E(SYNC_STAGES-1).
- Write: sys_wr_en is high for exactly the one cycle following edge E(SYNC_STAGES). sys_addr and sys_wdata are valid in that same cycle.
- Read:
  - sys_rd_en is high for the one cycle following E(SYNC_STAGES).
  - host_data_out is valid after E(SYNC_STAGES+2).
  - The host must hold ncs/nre low for at least SYNC_STAGES+3 clk periods before sampling data.
- Host address and data must be stable from strobe assertion until at least SYNC_STAGES+1 clk periods later.
- Minimum strobe-deasserted time between accesses: SYNC_STAGES+1 clk periods. A shorter gap may merge accesses; that is the host's responsibility.
- host_oe has no clk latency.
- Reset assertion clears outputs immediately, without waiting for clk.

## Test plan
- Write, SYNC_STAGES=2: addr 0x05, data 0xBEEF, strobes low for 8 cycles. Expect sys_wr_en high for exactly 1 cycle, 3 edges after pin assertion, with sys_addr=0x05 and sys_wdata=0xBEEF. Expect no sys_rd_en.
- Read: system returns 0x1234 for addr 0x2A. Expect sys_rd_en for 1 cycle and host_data_out=0x1234 by edge 5. Expect host_oe high exactly while ncs and nre are low. A held strobe of 20 cycles produces no second sys_rd_en.
- Back-to-back write then read, separated by a 3-cycle gap: expect exactly one sys_wr_en then one sys_rd_en, with correct addresses.
- nwe and nre low together: expect no sys strobes and err=1. Pulse err_clr: err=0. err_clr in the same cycle as a new error: err stays 1.
- Assert rst during RD_WAIT: all outputs 0 immediately. After rst falls with the host strobes still low, expect no access until the strobes go high and then low again.
- Parameter sweep DATA_W=32, ADDR_W=10, SYNC_STAGES=3: expect the write latency to become 4 edges and the data to pass through unchanged.

Source files
------------

// File: rtl/host_bus_sync_if_if.sv
// Debugger host bus plus system-side access bus, bundled for host_bus_sync_if.
// The slave modport is the bridge's view; master is the pads-plus-system environment.
interface host_bus_sync_if_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  logic              host_ncs;
  logic              host_nwe;
  logic              host_nre;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data_in;
  logic [DATA_W-1:0] host_data_out;
  logic              host_oe;
  logic [ADDR_W-1:0] sys_addr;
  logic [DATA_W-1:0] sys_wdata;
  logic              sys_wr_en;
  logic              sys_rd_en;
  logic [DATA_W-1:0] sys_rdata;
  logic              err_clr;
  logic              err;

  modport slave (
    input  host_ncs, host_nwe, host_nre, host_addr, host_data_in,
    output host_data_out, host_oe,
    output sys_addr, sys_wdata, sys_wr_en, sys_rd_en,
    input  sys_rdata,
    input  err_clr,
    output err
  );

  modport master (
    output host_ncs, host_nwe, host_nre, host_addr, host_data_in,
    input  host_data_out, host_oe,
    input  sys_addr, sys_wdata, sys_wr_en, sys_rd_en,
    output sys_rdata,
    output err_clr,
    input  err
  );
endinterface

// File: rtl/host_bus_sync_if.sv
// Synchronising bridge from the asynchronous debugger bus to single-cycle
// system read/write strobes, with read data held stable for the host.
module host_bus_sync_if #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  host_bus_sync_if_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RD_CAPT = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_ncs_sync;
  logic [SYNC_STAGES-1:0] r_nwe_sync;
  logic [SYNC_STAGES-1:0] r_nre_sync;
  logic [SYNC_STAGES-1:0] r_vld_sync;
  logic                   r_armed;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_wr_go;
  logic                   w_rd_go;
  logic                   w_err_set;
  logic                   w_capt;

  logic                   w_s_ncs;
  logic                   w_s_nwe;
  logic                   w_s_nre;
  logic                   w_sync_vld;
  logic                   w_released;

  logic [ADDR_W-1:0]      r_sys_addr;
  logic [DATA_W-1:0]      r_sys_wdata;
  logic [DATA_W-1:0]      r_host_data_out;
  logic                   r_wr_en;
  logic                   r_rd_en;
  logic                   r_err;

  // Synchroniser stage: r_vld_sync marks when the chain holds real pin samples
  // rather than its reset value, so a strobe held through reset is not mistaken
  // for a fresh assertion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ncs_sync <= '1;
      r_nwe_sync <= '1;
      r_nre_sync <= '1;
      r_vld_sync <= '0;
    end else begin
      r_ncs_sync <= {r_ncs_sync[SYNC_STAGES-2:0], bus.host_ncs};
      r_nwe_sync <= {r_nwe_sync[SYNC_STAGES-2:0], bus.host_nwe};
      r_nre_sync <= {r_nre_sync[SYNC_STAGES-2:0], bus.host_nre};
      r_vld_sync <= {r_vld_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign w_s_ncs    = r_ncs_sync[SYNC_STAGES-1];
  assign w_s_nwe    = r_nwe_sync[SYNC_STAGES-1];
  assign w_s_nre    = r_nre_sync[SYNC_STAGES-1];
  assign w_sync_vld = r_vld_sync[SYNC_STAGES-1];
  assign w_released = w_s_ncs | (w_s_nwe & w_s_nre);

  // Accesses are only accepted once the bus has been seen idle after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed <= 1'b0;
    end else if (w_sync_vld && w_released) begin
      r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_go     = 1'b0;
    w_rd_go     = 1'b0;
    w_err_set   = 1'b0;
    w_capt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_armed && !w_s_ncs) begin
          if (!w_s_nwe && !w_s_nre) begin
            w_err_set   = 1'b1;
            w_state_nxt = ST_HOLD;
          end else if (!w_s_nwe) begin
            w_wr_go     = 1'b1;
            w_state_nxt = ST_HOLD;
          end else if (!w_s_nre) begin
            w_rd_go     = 1'b1;
            w_state_nxt = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        w_state_nxt = ST_RD_CAPT;
      end
      ST_RD_CAPT: begin
        w_capt      = 1'b1;
        w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (w_released) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Access stage: address/data captured with the strobe decision, strobes
  // registered so they appear for exactly the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sys_addr      <= '0;
      r_sys_wdata     <= '0;
      r_host_data_out <= '0;
      r_wr_en         <= 1'b0;
      r_rd_en         <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_wr_en <= w_wr_go;
      r_rd_en <= w_rd_go;
      if (w_wr_go || w_rd_go) begin
        r_sys_addr <= bus.host_addr;
      end
      if (w_wr_go) begin
        r_sys_wdata <= bus.host_data_in;
      end
      if (w_capt) begin
        r_host_data_out <= bus.sys_rdata;
      end
      r_err <= w_err_set | (r_err & ~bus.err_clr);
    end
  end

  assign bus.sys_addr      = r_sys_addr;
  assign bus.sys_wdata     = r_sys_wdata;
  assign bus.sys_wr_en     = r_wr_en;
  assign bus.sys_rd_en     = r_rd_en;
  assign bus.host_data_out = r_host_data_out;
  assign bus.err           = r_err;
  // Pad drive enable follows the raw pins with no clock latency.
  assign bus.host_oe       = ~(bus.host_ncs | bus.host_nre);

endmodule

// File: tb/tb_host_bus_sync_if.sv
// Directed plus randomized bench for host_bus_sync_if at the default and a wide
// parameter set, checked against cycle-arithmetic expectations and a word memory.
module tb_host_bus_sync_if;

  logic clk;
  logic rst;
  int   cyc;
  int   ncheck;
  int   npass;
  int   nfail;

  host_bus_sync_if_if #(.DATA_W(16), .ADDR_W(6))  b0 ();
  host_bus_sync_if_if #(.DATA_W(32), .ADDR_W(10)) b1 ();

  host_bus_sync_if #(.DATA_W(16), .ADDR_W(6), .SYNC_STAGES(2)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  host_bus_sync_if #(.DATA_W(32), .ADDR_W(10), .SYNC_STAGES(3)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // System side: read data appears the cycle after the strobe, garbage otherwise.
  logic [15:0] rd_resp0;
  logic [31:0] rd_resp1;
  always @(posedge clk) begin
    b0.sys_rdata <= b0.sys_rd_en ? rd_resp0 : 16'($urandom);
    b1.sys_rdata <= b1.sys_rd_en ? rd_resp1 : $urandom;
  end

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t wr0[$];
  ev_t rd0[$];
  ev_t wr1[$];
  ev_t rd1[$];

  always @(negedge clk) begin
    if (b0.sys_wr_en === 1'b1) wr0.push_back('{cyc, 32'(b0.sys_addr), 32'(b0.sys_wdata)});
    if (b0.sys_rd_en === 1'b1) rd0.push_back('{cyc, 32'(b0.sys_addr), 32'd0});
    if (b1.sys_wr_en === 1'b1) wr1.push_back('{cyc, 32'(b1.sys_addr), b1.sys_wdata});
    if (b1.sys_rd_en === 1'b1) rd1.push_back('{cyc, 32'(b1.sys_addr), 32'd0});
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ncheck++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic int stages(int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic int wsz(int d);
    return (d == 0) ? wr0.size() : wr1.size();
  endfunction

  function automatic int rsz(int d);
    return (d == 0) ? rd0.size() : rd1.size();
  endfunction

  function automatic ev_t wfront(int d);
    return (d == 0) ? wr0[0] : wr1[0];
  endfunction

  function automatic ev_t rfront(int d);
    return (d == 0) ? rd0[0] : rd1[0];
  endfunction

  function automatic logic [31:0] hdo(int d);
    return (d == 0) ? 32'(b0.host_data_out) : b1.host_data_out;
  endfunction

  function automatic logic [31:0] oe(int d);
    return (d == 0) ? 32'(b0.host_oe) : 32'(b1.host_oe);
  endfunction

  task automatic clear_logs();
    wr0.delete();
    rd0.delete();
    wr1.delete();
    rd1.delete();
  endtask

  task automatic set_pins(int d, logic ncs, logic nwe, logic nre, logic [31:0] a, logic [31:0] dat);
    if (d == 0) begin
      b0.host_ncs     = ncs;
      b0.host_nwe     = nwe;
      b0.host_nre     = nre;
      b0.host_addr    = a[5:0];
      b0.host_data_in = dat[15:0];
    end else begin
      b1.host_ncs     = ncs;
      b1.host_nwe     = nwe;
      b1.host_nre     = nre;
      b1.host_addr    = a[9:0];
      b1.host_data_in = dat;
    end
  endtask

  task automatic do_write(int d, logic [31:0] a, logic [31:0] dat, int hold, int gap);
    int  t0;
    ev_t e;
    clear_logs();
    set_pins(d, 1'b0, 1'b0, 1'b1, a, dat);
    t0 = cyc;
    step(hold);
    set_pins(d, 1'b1, 1'b1, 1'b1, $urandom, $urandom);
    step(gap);
    chk("wr_count", wsz(d), 1);
    chk("wr_no_rd", rsz(d), 0);
    if (wsz(d) > 0) begin
      e = wfront(d);
      chk("wr_latency", e.cyc - t0, 1 + stages(d));
      chk("wr_addr", e.addr, a);
      chk("wr_data", e.data, dat);
    end
  endtask

  task automatic do_read(int d, logic [31:0] a, logic [31:0] resp, int hold, int gap);
    int          t0;
    int          s;
    ev_t         e;
    logic [31:0] old;
    s = stages(d);
    clear_logs();
    if (d == 0) rd_resp0 = resp[15:0];
    else        rd_resp1 = resp;
    old = hdo(d);
    chk("oe_idle", oe(d), 0);
    set_pins(d, 1'b0, 1'b1, 1'b0, a, $urandom);
    t0 = cyc;
    #1;
    chk("oe_active", oe(d), 1);
    step(s + 2);
    chk("rd_data_before_capt", hdo(d), old);
    step(1);
    chk("rd_data", hdo(d), resp);
    step(hold - (s + 3));
    chk("rd_data_held", hdo(d), resp);
    set_pins(d, 1'b1, 1'b1, 1'b1, $urandom, $urandom);
    #1;
    chk("oe_released", oe(d), 0);
    step(gap);
    chk("rd_count", rsz(d), 1);
    chk("rd_no_wr", wsz(d), 0);
    if (rsz(d) > 0) begin
      e = rfront(d);
      chk("rd_latency", e.cyc - t0, 1 + s);
      chk("rd_addr", e.addr, a);
    end
  endtask

  logic [31:0] ref_mem [int];
  int          keys[$];

  initial begin
    int          t0;
    int          k;
    logic [31:0] a;
    logic [31:0] dat;
    ncheck = 0;
    npass  = 0;
    nfail  = 0;
    rst    = 1'b1;
    rd_resp0 = '0;
    rd_resp1 = '0;
    b0.err_clr = 1'b0;
    b1.err_clr = 1'b0;
    set_pins(0, 1'b1, 1'b1, 1'b1, 0, 0);
    set_pins(1, 1'b1, 1'b1, 1'b1, 0, 0);

    step(3);
    chk("rst_wr_en", 32'(b0.sys_wr_en), 0);
    chk("rst_rd_en", 32'(b0.sys_rd_en), 0);
    chk("rst_err", 32'(b0.err), 0);
    chk("rst_hdo", hdo(0), 0);
    chk("rst_sys_addr", 32'(b0.sys_addr), 0);
    chk("rst_wr_en_wide", 32'(b1.sys_wr_en), 0);
    rst = 1'b0;
    step(8);

    // Basic write, long read with no repeat strobe, back-to-back pair.
    do_write(0, 32'h05, 32'hBEEF, 8, 4);
    do_read(0, 32'h2A, 32'h1234, 20, 4);
    do_write(0, 32'h11, 32'hA5A5, 6, 3);
    do_read(0, 32'h22, 32'h5A5A, 6, 4);

    // Simultaneous strobes raise err without any system access.
    clear_logs();
    set_pins(0, 1'b0, 1'b0, 1'b0, 32'h03, 32'h77);
    step(6);
    set_pins(0, 1'b1, 1'b1, 1'b1, 0, 0);
    step(4);
    chk("err_set", 32'(b0.err), 1);
    chk("err_no_wr", wsz(0), 0);
    chk("err_no_rd", rsz(0), 0);
    b0.err_clr = 1'b1;
    step(1);
    b0.err_clr = 1'b0;
    chk("err_cleared", 32'(b0.err), 0);
    set_pins(0, 1'b0, 1'b0, 1'b0, 32'h04, 32'h88);
    step(2);
    b0.err_clr = 1'b1;
    chk("err_before_set", 32'(b0.err), 0);
    step(1);
    b0.err_clr = 1'b0;
    chk("err_set_beats_clr", 32'(b0.err), 1);
    step(4);
    set_pins(0, 1'b1, 1'b1, 1'b1, 0, 0);
    step(4);
    chk("err_sticky", 32'(b0.err), 1);

    // Reset in the cycle the read strobe is high, with err still set.
    clear_logs();
    rd_resp0 = 16'h0F0F;
    set_pins(0, 1'b0, 1'b1, 1'b0, 32'h15, 0);
    t0 = cyc;
    step(3);
    chk("pre_rst_rd_en", 32'(b0.sys_rd_en), 1);
    rst = 1'b1;
    #1;
    chk("arst_rd_en", 32'(b0.sys_rd_en), 0);
    chk("arst_wr_en", 32'(b0.sys_wr_en), 0);
    chk("arst_err", 32'(b0.err), 0);
    chk("arst_hdo", hdo(0), 0);
    chk("arst_sys_addr", 32'(b0.sys_addr), 0);
    chk("arst_sys_wdata", 32'(b0.sys_wdata), 0);
    step(2);
    rst = 1'b0;
    clear_logs();
    step(12);
    chk("post_rst_no_rd", rsz(0), 0);
    chk("post_rst_no_wr", wsz(0), 0);
    set_pins(0, 1'b1, 1'b1, 1'b1, 0, 0);
    step(4);
    do_read(0, 32'h15, 32'h0F0F, 8, 4);

    // Random writes into a word memory, each followed by a read-back.
    for (int i = 0; i < 8; i++) begin
      a   = 32'($urandom_range(63, 0));
      dat = 32'($urandom_range(16'hFFFF, 0));
      do_write(0, a, dat, int'($urandom_range(10, 4)), int'($urandom_range(5, 3)));
      if (!ref_mem.exists(int'(a))) keys.push_back(int'(a));
      ref_mem[int'(a)] = dat;
      k = keys[$urandom_range(keys.size() - 1, 0)];
      do_read(0, 32'(k), ref_mem[k], int'($urandom_range(10, 5)), int'($urandom_range(5, 3)));
    end

    // Wide instance with a three-flop synchroniser.
    do_write(1, 32'h3A5, 32'hDEADBEEF, 8, 5);
    do_read(1, 32'h155, 32'hCAFEF00D, 9, 5);
    do_write(1, 32'($urandom_range(1023, 0)), $urandom, 7, 4);

    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end

endmodule
